inst_server: RTL

INST_SERVER -- requirements
Module: inst_server

---
 rtl/inst_server_pkg.sv | 17 +
 rtl/inst_ram.sv | 28 ++
 rtl/inst_server.sv | 132 +++++++++++++
 3 files changed

// File: rtl/inst_server_pkg.sv
// Shared definitions for the instruction server: NOP encoding, FSM states,
// and default memory geometry.
package inst_server_pkg;

  localparam int DEPTH_DEFAULT  = 1024;
  localparam int ADDR_W_DEFAULT = 10;

  localparam logic [15:0] INST_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOAD_LO = 2'd1,
    ST_LOAD_HI = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/inst_ram.sv
// Single-port synchronous instruction RAM, DEPTH x 16, one-cycle read,
// write-first (a write also presents the new word on rdata).
module inst_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/inst_server.sv
// Instruction server: assembles a byte-serial program load into 16-bit words
// in inst_ram and serves one-cycle-latency fetches once the load has ended.
module inst_server
  import inst_server_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [15:0]       fetch_pc,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_end,
  output logic              loading,
  output logic              ld_overflow,
  output logic [ADDR_W:0]   word_count
);

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     wr_ptr_reg;
  logic [7:0]          lo_byte_reg;
  logic                ovf_reg;
  logic                rd_pend_reg, nop_pend_reg, valid_reg;
  logic [15:0]         hold_reg;

  logic                clr_load, latch_lo, word_done;
  logic                ptr_full, wr_en, rd_en, in_range, run_fetch;
  logic [ADDR_W-1:0]   ram_addr;
  logic [15:0]         ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_EMPTY;
    else     state_reg <= state_next;
  end

  // ld_start outranks everything; in LOAD_HI a word arriving with ld_end is
  // still written before the move to RUN.
  always_comb begin
    state_next = state_reg;
    clr_load   = 1'b0;
    latch_lo   = 1'b0;
    word_done  = 1'b0;
    case (state_reg)
      ST_EMPTY, ST_RUN: begin
        if (ld_start) begin
          state_next = ST_LOAD_LO;
          clr_load   = 1'b1;
        end
      end
      ST_LOAD_LO: begin
        if (ld_start) begin
          state_next = ST_LOAD_LO;
          clr_load   = 1'b1;
        end else if (ld_end) begin
          state_next = ST_RUN;
        end else if (ld_valid) begin
          latch_lo   = 1'b1;
          state_next = ST_LOAD_HI;
        end
      end
      ST_LOAD_HI: begin
        if (ld_start) begin
          state_next = ST_LOAD_LO;
          clr_load   = 1'b1;
        end else begin
          word_done = ld_valid;
          if (ld_end)        state_next = ST_RUN;
          else if (ld_valid) state_next = ST_LOAD_LO;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  assign ptr_full  = (wr_ptr_reg == (ADDR_W+1)'(DEPTH));
  assign wr_en     = word_done && !ptr_full;
  assign run_fetch = (state_reg == ST_RUN) && fetch_req;
  assign in_range  = (fetch_pc < 16'(wr_ptr_reg));
  assign rd_en     = run_fetch && in_range;
  assign ram_addr  = wr_en ? wr_ptr_reg[ADDR_W-1:0] : fetch_pc[ADDR_W-1:0];

  inst_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (wr_en | rd_en),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata ({ld_byte, lo_byte_reg}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      lo_byte_reg  <= '0;
      ovf_reg      <= 1'b0;
      rd_pend_reg  <= 1'b0;
      nop_pend_reg <= 1'b0;
      valid_reg    <= 1'b0;
      hold_reg     <= INST_NOP;
    end else begin
      if (clr_load) begin
        wr_ptr_reg <= '0;
        ovf_reg    <= 1'b0;
      end else if (word_done) begin
        if (ptr_full) ovf_reg    <= 1'b1;
        else          wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (latch_lo) lo_byte_reg <= ld_byte;
      // A read issued alongside ld_start still completes but is not flagged valid.
      rd_pend_reg  <= rd_en;
      nop_pend_reg <= run_fetch && !in_range;
      valid_reg    <= run_fetch && !ld_start;
      hold_reg     <= inst;
    end
  end

  assign inst        = rd_pend_reg  ? ram_rdata :
                       nop_pend_reg ? INST_NOP  : hold_reg;
  assign inst_valid  = valid_reg;
  assign loading     = (state_reg == ST_LOAD_LO) || (state_reg == ST_LOAD_HI);
  assign ld_overflow = ovf_reg;
  assign word_count  = wr_ptr_reg;

endmodule
